// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - round-robin arbiter sharing one memory request/response channel; optional timeout via MEM_REQ_ARBITER_TIMEOUT_EN
module mem_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_vld,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_rdy,
  output logic [NUM_REQ-1:0]            rsp_vld,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  input  logic [NUM_REQ-1:0]            rsp_rdy,
  output logic                          m_req_vld,
  input  logic                          m_req_rdy,
  output logic                          m_req_we,
  output logic [ADDR_WIDTH-1:0]         m_req_addr,
  output logic [DATA_WIDTH-1:0]         m_req_wdata,
  input  logic                          m_rsp_vld,
  input  logic [DATA_WIDTH-1:0]         m_rsp_data,
  output logic                          m_rsp_rdy,
  output logic                          busy
`ifdef MEM_REQ_ARBITER_TIMEOUT_EN
  ,
  output logic                          timeout_err
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GRANT    = 3'd1,
    ISSUE    = 3'd2,
    WAIT_RSP = 3'd3,
    RESPOND  = 3'd4
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   winner;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  logic [NUM_REQ-1:0] vld_rot;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_ofs;
  logic [IDX_W:0]     pick_sum;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   next_ptr;

`ifdef MEM_REQ_ARBITER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
`endif

  // Unpack the per-requester address and write-data slices
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Rotate requests so the pointer sits at bit 0, find the lowest set bit, then map back
  always_comb begin
    vld_rot    = NUM_REQ'({req_vld, req_vld} >> ptr);
    pick_found = 1'b0;
    pick_ofs   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (vld_rot[i]) begin
        pick_found = 1'b1;
        pick_ofs   = IDX_W'(i);
      end
    end
    pick_sum = {1'b0, ptr} + {1'b0, pick_ofs};
    if (pick_sum >= (IDX_W+1)'(NUM_REQ)) begin
      pick_idx = IDX_W'(pick_sum - (IDX_W+1)'(NUM_REQ));
    end else begin
      pick_idx = IDX_W'(pick_sum);
    end
  end

  // Pointer moves just past the requester that completed a transaction
  assign next_ptr = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);

  // Transaction FSM; every output is a register updated on state transitions
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      winner      <= '0;
      req_rdy     <= '0;
      rsp_vld     <= '0;
      rsp_data    <= '0;
      m_req_vld   <= 1'b0;
      m_req_we    <= 1'b0;
      m_req_addr  <= '0;
      m_req_wdata <= '0;
      m_rsp_rdy   <= 1'b0;
      busy        <= 1'b0;
`ifdef MEM_REQ_ARBITER_TIMEOUT_EN
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
`ifdef MEM_REQ_ARBITER_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (pick_found) begin
            winner  <= pick_idx;
            req_rdy <= NUM_REQ'(1) << pick_idx;
            busy    <= 1'b1;
            state   <= GRANT;
          end
        end
        GRANT: begin
          req_rdy <= '0;
          // A requester that withdrew during its grant cycle forfeits the turn but keeps the pointer
          if (req_vld[winner]) begin
            m_req_we    <= req_we[winner];
            m_req_addr  <= addr_arr[winner];
            m_req_wdata <= wdata_arr[winner];
            m_req_vld   <= 1'b1;
            state       <= ISSUE;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        ISSUE: begin
          if (m_req_rdy) begin
            m_req_vld <= 1'b0;
            m_rsp_rdy <= 1'b1;
`ifdef MEM_REQ_ARBITER_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
            state     <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          // A real response beats an expiry landing in the same cycle
          if (m_rsp_vld) begin
            rsp_data  <= m_rsp_data;
            rsp_vld   <= NUM_REQ'(1) << winner;
            m_rsp_rdy <= 1'b0;
            state     <= RESPOND;
          end
`ifdef MEM_REQ_ARBITER_TIMEOUT_EN
          else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            rsp_data    <= '1;
            rsp_vld     <= NUM_REQ'(1) << winner;
            m_rsp_rdy   <= 1'b0;
            timeout_err <= 1'b1;
            state       <= RESPOND;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
`endif
        end
        RESPOND: begin
          if (rsp_rdy[winner]) begin
            rsp_vld <= '0;
            ptr     <= next_ptr;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          req_rdy   <= '0;
          rsp_vld   <= '0;
          m_req_vld <= 1'b0;
          m_rsp_rdy <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb/tb_mem_req_arbiter.sv - directed self-checking bench for mem_req_arbiter
module tb_mem_req_arbiter;

`ifdef MEM_REQ_ARBITER_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif

  logic        clk;
  logic        reset;
  logic [3:0]  req_vld;
  logic [3:0]  req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_rdy;
  logic [3:0]  rsp_vld;
  logic [7:0]  rsp_data;
  logic [3:0]  rsp_rdy;
  logic        m_req_vld;
  logic        m_req_rdy;
  logic        m_req_we;
  logic [7:0]  m_req_addr;
  logic [7:0]  m_req_wdata;
  logic        m_rsp_vld;
  logic [7:0]  m_rsp_data;
  logic        m_rsp_rdy;
  logic        busy;
`ifdef MEM_REQ_ARBITER_TIMEOUT_EN
  logic        timeout_err;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int n_mreq = 0;
  int n_rsp = 0;

  logic [7:0] exp_addr  [4] = '{8'h12, 8'h21, 8'h22, 8'h23};
  logic [7:0] exp_wdata [4] = '{8'h4A, 8'h3C, 8'h4C, 8'h4D};
  logic       exp_we    [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  mem_req_arbiter #(
    .NUM_REQ(4), .ADDR_WIDTH(8), .DATA_WIDTH(8), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_vld(req_vld), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rdy(req_rdy), .rsp_vld(rsp_vld), .rsp_data(rsp_data), .rsp_rdy(rsp_rdy),
    .m_req_vld(m_req_vld), .m_req_rdy(m_req_rdy), .m_req_we(m_req_we),
    .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata),
    .m_rsp_vld(m_rsp_vld), .m_rsp_data(m_rsp_data), .m_rsp_rdy(m_rsp_rdy),
    .busy(busy)
`ifdef MEM_REQ_ARBITER_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (m_req_vld && m_req_rdy) n_mreq <= n_mreq + 1;
    if (|(rsp_vld & rsp_rdy)) n_rsp <= n_rsp + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Runs one transaction for requester w, starting at the IDLE negedge before arbitration
  task automatic txn(input int w, input logic [7:0] rd, input int req_stall,
                     input int mem_dly, input int rsp_stall, input bit drop);
    logic [3:0] oh;
    oh = 4'(1 << w);
    @(negedge clk);
    check("grant_req_rdy", req_rdy, oh);
    check("grant_busy", busy, 1);
    @(negedge clk);
    if (drop) req_vld[w] = 1'b0;
    check("issue_vld", m_req_vld, 1);
    check("issue_addr", m_req_addr, exp_addr[w]);
    check("issue_we", m_req_we, exp_we[w]);
    check("issue_wdata", m_req_wdata, exp_wdata[w]);
    check("issue_req_rdy_clr", req_rdy, 0);
    for (int s = 0; s < req_stall; s++) begin
      m_req_rdy = 1'b0;
      @(negedge clk);
      check("stall_vld", m_req_vld, 1);
      check("stall_addr", m_req_addr, exp_addr[w]);
      check("stall_wdata", m_req_wdata, exp_wdata[w]);
    end
    m_req_rdy = 1'b1;
    @(negedge clk);
    m_req_rdy = 1'b0;
    check("wait_vld_clr", m_req_vld, 0);
    check("wait_m_rsp_rdy", m_rsp_rdy, 1);
    repeat (mem_dly) @(negedge clk);
    m_rsp_vld  = 1'b1;
    m_rsp_data = rd;
    @(negedge clk);
    m_rsp_vld  = 1'b0;
    m_rsp_data = ~rd;
    check("rsp_vld", rsp_vld, oh);
    check("rsp_data", rsp_data, rd);
    check("rsp_m_rsp_rdy_clr", m_rsp_rdy, 0);
    for (int s = 0; s < rsp_stall; s++) begin
      @(negedge clk);
      check("rstall_vld", rsp_vld, oh);
      check("rstall_data", rsp_data, rd);
    end
    rsp_rdy = oh;
    @(negedge clk);
    rsp_rdy = 4'b0;
    check("done_rsp_vld", rsp_vld, 0);
  endtask

  initial begin
    int mreq0, rsp0;
    bit seen;
    reset      = 1'b1;
    req_vld    = 4'b0;
    req_we     = 4'b0010;
    req_addr   = {8'h23, 8'h22, 8'h21, 8'h12};
    req_wdata  = {8'h4D, 8'h4C, 8'h3C, 8'h4A};
    rsp_rdy    = 4'b0;
    m_req_rdy  = 1'b0;
    m_rsp_vld  = 1'b0;
    m_rsp_data = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_req_rdy", req_rdy, 0);
    check("rst_rsp_vld", rsp_vld, 0);
    check("rst_m_req_vld", m_req_vld, 0);
    check("rst_m_rsp_rdy", m_rsp_rdy, 0);
    check("rst_m_req_addr", m_req_addr, 0);
    check("rst_rsp_data", rsp_data, 0);
    reset = 1'b0;

    // Stray memory response while idle
    m_rsp_vld = 1'b1; m_rsp_data = 8'h77;
    @(negedge clk);
    check("stray_m_rsp_rdy", m_rsp_rdy, 0);
    check("stray_busy", busy, 0);
    @(negedge clk);
    m_rsp_vld = 1'b0;
    check("stray_rsp_vld", rsp_vld, 0);
    check("stray_rsp_data", rsp_data, 0);

    // Single read from requester 0, memory answers after 3 cycles
    req_vld = 4'b0001;
    txn(0, 8'hA5, 0, 3, 0, 1'b1);
    check("single_busy_drop", busy, 0);

    // Contention from pointer 0: 0,1,2,3 then 0 again
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req_vld = 4'b1111;
    for (int k = 0; k < 5; k++) txn(k % 4, 8'(8'h50 + k), 0, 0, 0, 1'b0);
    req_vld = 4'b0000;

    // Pointer is 1; a lone grant to 2 moves it to 3, then 0101 wraps to 0 then 2
    req_vld = 4'b0100;
    txn(2, 8'h61, 0, 0, 0, 1'b1);
    req_vld = 4'b0101;
    txn(0, 8'h62, 0, 0, 0, 1'b0);
    txn(2, 8'h63, 0, 0, 0, 1'b0);
    req_vld = 4'b0000;

    // Withdraw during grant: back to idle, pointer stays at 3
    req_vld = 4'b1000;
    @(negedge clk);
    check("abort_req_rdy", req_rdy, 4'b1000);
    req_vld = 4'b0000;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_m_req_vld", m_req_vld, 0);
    req_vld = 4'b1001;
    txn(3, 8'h64, 0, 0, 0, 1'b1);
    req_vld = 4'b0000;

    // Backpressure on both sides, write from requester 1
    mreq0 = n_mreq;
    rsp0  = n_rsp;
    req_vld = 4'b0010;
    txn(1, 8'h5A, 5, 1, 4, 1'b1);
    check("bp_mreq_hs", n_mreq - mreq0, 1);
    check("bp_rsp_hs", n_rsp - rsp0, 1);

    // Reset while waiting for the memory response
    req_vld = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    req_vld = 4'b0000;
    m_req_rdy = 1'b1;
    @(negedge clk);
    m_req_rdy = 1'b0;
    check("pre_rst_m_rsp_rdy", m_rsp_rdy, 1);
    #2 reset = 1'b1;
    #1;
    check("async_m_rsp_rdy", m_rsp_rdy, 0);
    check("async_busy", busy, 0);
    check("async_m_req_addr", m_req_addr, 0);
    @(negedge clk);
    reset = 1'b0;
    m_rsp_vld = 1'b1; m_rsp_data = 8'h99;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_rsp_vld", rsp_vld, 0);
      check("post_rst_busy", busy, 0);
    end
    m_rsp_vld = 1'b0;

`ifdef MEM_REQ_ARBITER_TIMEOUT_EN
    // Memory never answers: timeout after TMO cycles delivers all ones
    req_vld = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    req_vld = 4'b0000;
    m_req_rdy = 1'b1;
    @(negedge clk);
    m_req_rdy = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (timeout_err) seen = 1'b1;
    end
    check("tmo_seen", seen, 1);
    check("tmo_rsp_vld", rsp_vld, 4'b0001);
    check("tmo_rsp_data", rsp_data, 8'hFF);
    @(negedge clk);
    check("tmo_pulse_clr", timeout_err, 0);
    rsp_rdy = 4'b0001;
    @(negedge clk);
    rsp_rdy = 4'b0000;
    check("tmo_idle", busy, 0);
`else
    seen = 1'b0;
    check("no_tmo_seen", seen, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
